// File: rtl/hdmi_packet_sender.sv
// HDMI data-island packet sender: builds ACR / audio / AVI / null packets, waits for a blanking
// window, and streams preamble, guard bands and the 32-clock data period as TERC4 nibbles.
module hdmi_packet_sender #(
    parameter int unsigned PREAMBLE_LEN   = 8,
    parameter int unsigned AUDIO_CHANNELS = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        packet_needed,
    input  logic        audio_regen,
    input  logic        audio_info,
    input  logic        video_info,
    input  logic [19:0] cts,
    input  logic [19:0] n,
    input  logic [6:0]  vic,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        island_ok,
    output logic        packet_sent,
    output logic        preamble,
    output logic        guard,
    output logic        data_island,
    output logic [3:0]  ch0_nibble,
    output logic [3:0]  ch1_nibble,
    output logic [3:0]  ch2_nibble
);

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StPreamble,
        StLeadGuard,
        StData,
        StTrailGuard,
        StDone
    } state_e;

    localparam logic [4:0] PreLast = 5'(PREAMBLE_LEN - 1);

    function automatic logic [7:0] ecc_step(input logic [7:0] ecc, input logic bit_i);
        return (ecc >> 1) ^ (((ecc[0] ^ bit_i) == 1'b1) ? 8'h83 : 8'h00);
    endfunction

    state_e            state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic              armed_q, armed_d;
    logic [23:0]       hdr_q, hdr_d;
    logic [7:0]        hdr_ecc_q, hdr_ecc_d;
    logic [3:0][55:0]  sp_q, sp_d;
    logic [3:0][7:0]   sp_ecc_q, sp_ecc_d;

    logic [23:0]       build_hb;
    logic [3:0][55:0]  build_sp;
    logic [13:0][7:0]  pb;
    logic [7:0]        csum;
    logic              hdr_bit;

    // Packet image for the currently selected type; only sampled when leaving IDLE.
    always_comb begin
        build_hb = '0;
        build_sp = '0;
        pb       = '0;
        csum     = '0;
        if (audio_regen) begin
            build_hb = {8'h00, 8'h00, 8'h01};
            for (int i = 0; i < 4; i++) begin
                build_sp[i] = {n[7:0], n[15:8], {4'h0, n[19:16]},
                               cts[7:0], cts[15:8], {4'h0, cts[19:16]}, 8'h00};
            end
        end else if (audio_info || video_info) begin
            if (audio_info) begin
                build_hb = {8'h0A, 8'h01, 8'h84};
                pb[1]    = 8'(AUDIO_CHANNELS - 1);
            end else begin
                build_hb = {8'h0D, 8'h02, 8'h82};
                pb[1]    = 8'h10;
                pb[2]    = 8'h08;
                pb[4]    = {1'b0, vic};
            end
            csum = build_hb[7:0] + build_hb[15:8] + build_hb[23:16];
            for (int i = 1; i < 14; i++) begin
                csum = csum + pb[i];
            end
            pb[0]       = 8'h00 - csum;
            build_sp[0] = pb[6:0];
            build_sp[1] = pb[13:7];
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        armed_d     = armed_q;
        hdr_d       = hdr_q;
        hdr_ecc_d   = hdr_ecc_q;
        sp_d        = sp_q;
        sp_ecc_d    = sp_ecc_q;
        hdr_bit     = 1'b0;
        packet_sent = 1'b0;
        preamble    = 1'b0;
        guard       = 1'b0;
        data_island = 1'b0;
        ch0_nibble  = 4'h0;
        ch1_nibble  = 4'h0;
        ch2_nibble  = 4'h0;

        unique case (state_q)
            StIdle: begin
                if (armed_q && packet_needed) begin
                    hdr_d     = build_hb;
                    hdr_ecc_d = '0;
                    sp_d      = build_sp;
                    sp_ecc_d  = '0;
                    state_d   = StWait;
                end
            end
            StWait: begin
                if (island_ok) begin
                    cnt_d   = '0;
                    state_d = StPreamble;
                end
            end
            StPreamble: begin
                preamble = 1'b1;
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == PreLast) begin
                    cnt_d   = '0;
                    state_d = StLeadGuard;
                end
            end
            StLeadGuard: begin
                guard = 1'b1;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd1) begin
                    cnt_d   = '0;
                    state_d = StData;
                end
            end
            StData: begin
                data_island = 1'b1;
                cnt_d       = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    cnt_d   = '0;
                    state_d = StTrailGuard;
                end
                // Header: 24 data bits then the parity byte drains out LSB first.
                if (cnt_q < 5'd24) begin
                    hdr_bit   = hdr_q[0];
                    hdr_d     = hdr_q >> 1;
                    hdr_ecc_d = ecc_step(hdr_ecc_q, hdr_q[0]);
                end else begin
                    hdr_bit   = hdr_ecc_q[0];
                    hdr_ecc_d = hdr_ecc_q >> 1;
                end
                ch0_nibble = {(cnt_q != 5'd0), hdr_bit, vsync, hsync};
                // Subpackets: two bits per clock, 56 data bits then the parity byte.
                for (int i = 0; i < 4; i++) begin
                    if (cnt_q < 5'd28) begin
                        ch1_nibble[i] = sp_q[i][0];
                        ch2_nibble[i] = sp_q[i][1];
                        sp_d[i]       = sp_q[i] >> 2;
                        sp_ecc_d[i]   = ecc_step(ecc_step(sp_ecc_q[i], sp_q[i][0]), sp_q[i][1]);
                    end else begin
                        ch1_nibble[i] = sp_ecc_q[i][0];
                        ch2_nibble[i] = sp_ecc_q[i][1];
                        sp_ecc_d[i]   = sp_ecc_q[i] >> 2;
                    end
                end
            end
            StTrailGuard: begin
                guard = 1'b1;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd1) begin
                    cnt_d   = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                packet_sent = 1'b1;
                armed_d     = 1'b0;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // A request still held after completion must drop before it can be served again.
        if (!packet_needed) begin
            armed_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            armed_q   <= 1'b1;
            hdr_q     <= '0;
            hdr_ecc_q <= '0;
            sp_q      <= '0;
            sp_ecc_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            armed_q   <= armed_d;
            hdr_q     <= hdr_d;
            hdr_ecc_q <= hdr_ecc_d;
            sp_q      <= sp_d;
            sp_ecc_q  <= sp_ecc_d;
        end
    end

endmodule

// File: tb/tb_hdmi_packet_sender.sv
// Bench for hdmi_packet_sender: byte-level packet model with serial BCH parity, cycle-exact
// phase expectations, randomized fields and sync activity.
module tb_hdmi_packet_sender;

    localparam int unsigned PL = 8;
    localparam int unsigned AC = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        packet_needed, audio_regen, audio_info, video_info;
    logic [19:0] cts, n;
    logic [6:0]  vic;
    logic        hsync, vsync, island_ok;
    logic        packet_sent, preamble, guard, data_island;
    logic [3:0]  ch0_nibble, ch1_nibble, ch2_nibble;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_hdr;
    logic [63:0] exp_sp [4];
    logic [31:0] cap_hdr;
    logic [63:0] cap_sp [4];

    hdmi_packet_sender #(
        .PREAMBLE_LEN  (PL),
        .AUDIO_CHANNELS(AC)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .packet_needed(packet_needed),
        .audio_regen  (audio_regen),
        .audio_info   (audio_info),
        .video_info   (video_info),
        .cts          (cts),
        .n            (n),
        .vic          (vic),
        .hsync        (hsync),
        .vsync        (vsync),
        .island_ok    (island_ok),
        .packet_sent  (packet_sent),
        .preamble     (preamble),
        .guard        (guard),
        .data_island  (data_island),
        .ch0_nibble   (ch0_nibble),
        .ch1_nibble   (ch1_nibble),
        .ch2_nibble   (ch2_nibble)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] obs_vec();
        return {packet_sent, preamble, guard, data_island, ch0_nibble, ch1_nibble, ch2_nibble};
    endfunction

    function automatic logic [7:0] bch(input logic [7:0] e, input logic b);
        return (e >> 1) ^ (((e[0] ^ b) == 1'b1) ? 8'h83 : 8'h00);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Packet as bytes, then serialised LSB first with parity appended.
    task automatic model_build(input logic ar, input logic ai, input logic vi,
                               input logic [19:0] c, input logic [19:0] nn,
                               input logic [6:0] v);
        logic [7:0] hb [3];
        logic [7:0] sb [4][7];
        logic [7:0] pb [14];
        logic [7:0] e;
        int         sum;
        for (int i = 0; i < 3; i++) hb[i] = 8'h00;
        for (int i = 0; i < 14; i++) pb[i] = 8'h00;
        for (int i = 0; i < 4; i++) for (int j = 0; j < 7; j++) sb[i][j] = 8'h00;
        if (ar) begin
            hb[0] = 8'h01;
            for (int i = 0; i < 4; i++) begin
                sb[i][1] = {4'h0, c[19:16]};
                sb[i][2] = c[15:8];
                sb[i][3] = c[7:0];
                sb[i][4] = {4'h0, nn[19:16]};
                sb[i][5] = nn[15:8];
                sb[i][6] = nn[7:0];
            end
        end else if (ai || vi) begin
            if (ai) begin
                hb[0] = 8'h84; hb[1] = 8'h01; hb[2] = 8'h0A;
                pb[1] = 8'(AC - 1);
            end else begin
                hb[0] = 8'h82; hb[1] = 8'h02; hb[2] = 8'h0D;
                pb[1] = 8'h10; pb[2] = 8'h08; pb[4] = {1'b0, v};
            end
            sum = int'(hb[0]) + int'(hb[1]) + int'(hb[2]);
            for (int i = 1; i < 14; i++) sum += int'(pb[i]);
            pb[0] = 8'((256 - (sum % 256)) % 256);
            for (int j = 0; j < 7; j++) begin
                sb[0][j] = pb[j];
                sb[1][j] = pb[7 + j];
            end
        end
        exp_hdr = '0;
        e = 8'h00;
        for (int b = 0; b < 24; b++) begin
            exp_hdr[b] = hb[b / 8][b % 8];
            e = bch(e, exp_hdr[b]);
        end
        exp_hdr[31:24] = e;
        for (int i = 0; i < 4; i++) begin
            exp_sp[i] = '0;
            e = 8'h00;
            for (int b = 0; b < 56; b++) begin
                exp_sp[i][b] = sb[i][b / 8][b % 8];
                e = bch(e, exp_sp[i][b]);
            end
            exp_sp[i][63:56] = e;
        end
    endtask

    // One full request: w clocks of island_ok=0 in WAIT, hold clocks of request held after done.
    task automatic run_packet(input string tag, input logic ar, input logic ai, input logic vi,
                              input logic [19:0] c, input logic [19:0] nn, input logic [6:0] v,
                              input int w, input int hold);
        int         pre_start, total, j, k;
        logic [15:0] exp;
        model_build(ar, ai, vi, c, nn, v);
        cap_hdr = '0;
        for (int i = 0; i < 4; i++) cap_sp[i] = '0;
        pre_start = ((w < 1) ? 1 : w) + 1;
        total     = pre_start + int'(PL) + 36;
        @(negedge clock);
        audio_regen   = ar;
        audio_info    = ai;
        video_info    = vi;
        cts           = c;
        n             = nn;
        vic           = v;
        island_ok     = (w == 0);
        packet_needed = 1'b1;
        for (int s = 1; s <= total; s++) begin
            @(negedge clock);
            j   = s - pre_start;
            exp = '0;
            if (j >= 0 && j < int'(PL)) begin
                exp[14] = 1'b1;
            end else if (j >= int'(PL) && j < int'(PL) + 2) begin
                exp[13] = 1'b1;
            end else if (j >= int'(PL) + 2 && j < int'(PL) + 34) begin
                k        = j - int'(PL) - 2;
                exp[12]  = 1'b1;
                exp[11]  = (k != 0);
                exp[10]  = exp_hdr[k];
                exp[9]   = vsync;
                exp[8]   = hsync;
                for (int i = 0; i < 4; i++) begin
                    exp[4 + i]             = exp_sp[i][2 * k];
                    exp[i]                 = exp_sp[i][2 * k + 1];
                    cap_sp[i][2 * k]       = ch1_nibble[i];
                    cap_sp[i][2 * k + 1]   = ch2_nibble[i];
                end
                cap_hdr[k] = ch0_nibble[2];
            end else if (j >= int'(PL) + 34 && j < int'(PL) + 36) begin
                exp[13] = 1'b1;
            end else if (j == int'(PL) + 36) begin
                exp[15] = 1'b1;
            end
            tests++;
            assert (obs_vec() === exp) else begin
                fails++;
                $error("FAIL %s cycle %0d: got %h want %h", tag, s, obs_vec(), exp);
            end
            hsync = 1'($urandom);
            vsync = 1'($urandom);
            if (w > 0 && s == w) island_ok = 1'b1;
            if (j >= 0) island_ok = 1'($urandom);
            // Latched at the first edge; later changes must have no effect.
            audio_regen = 1'($urandom);
            audio_info  = 1'($urandom);
            video_info  = 1'($urandom);
            cts         = 20'($urandom);
            n           = 20'($urandom);
            vic         = 7'($urandom);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clock);
            check({tag, "_hold"}, 64'(obs_vec()), 64'h0);
        end
        packet_needed = 1'b0;
        island_ok     = 1'b0;
        @(negedge clock);
        check({tag, "_idle"}, 64'(obs_vec()), 64'h0);
    endtask

    initial begin
        reset         = 1'b1;
        packet_needed = 1'b0;
        audio_regen   = 1'b0;
        audio_info    = 1'b0;
        video_info    = 1'b0;
        cts           = '0;
        n             = '0;
        vic           = '0;
        hsync         = 1'b0;
        vsync         = 1'b0;
        island_ok     = 1'b0;
        #1;
        check("reset_state", 64'(obs_vec()), 64'h0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        run_packet("audio_info", 1'b0, 1'b1, 1'b0, 20'h0, 20'h0, 7'h0, 0, 0);
        check("ainfo_sb01", 64'(cap_sp[0][15:0]), 64'h0170);
        check("ainfo_hdr_ecc", 64'(cap_hdr), 64'(exp_hdr));

        run_packet("avi", 1'b0, 1'b0, 1'b1, 20'h0, 20'h0, 7'd16, 0, 0);
        check("avi_pb0", 64'(cap_sp[0][7:0]), 64'h47);
        check("avi_pb4", 64'(cap_sp[0][39:32]), 64'h10);

        run_packet("acr_prio", 1'b1, 1'b0, 1'b1, 20'h1234A, 20'h01800, 7'd5, 0, 8);
        for (int i = 0; i < 4; i++) begin
            check("acr_sp_bytes", 64'(cap_sp[i][55:0]), 64'h0000_1800_4A23_0100);
            check("acr_sp_ecc", cap_sp[i], exp_sp[i]);
        end

        run_packet("null_wait100", 1'b0, 1'b0, 1'b0, 20'hFFFFF, 20'hFFFFF, 7'h7F, 100, 0);
        check("null_hdr", 64'(cap_hdr), 64'h0);
        for (int i = 0; i < 4; i++) check("null_sp", cap_sp[i], 64'h0);

        for (int r = 0; r < 6; r++) begin
            run_packet("rand", 1'($urandom), 1'($urandom), 1'($urandom), 20'($urandom),
                       20'($urandom), 7'($urandom), int'($urandom_range(0, 5)),
                       int'($urandom_range(0, 3)));
        end

        // Abort in the middle of the data period.
        @(negedge clock);
        audio_info    = 1'b1;
        audio_regen   = 1'b0;
        video_info    = 1'b0;
        island_ok     = 1'b1;
        packet_needed = 1'b1;
        for (int s = 1; s <= 2 + int'(PL) + 2 + 10; s++) @(negedge clock);
        check("mid_data_k10", 64'({data_island, ch0_nibble[3]}), 64'h3);
        #1;
        reset         = 1'b1;
        packet_needed = 1'b0;
        island_ok     = 1'b0;
        #1;
        check("reset_abort", 64'(obs_vec()), 64'h0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int s = 0; s < 20; s++) begin
            @(negedge clock);
            check("post_abort_quiet", 64'(obs_vec()), 64'h0);
        end
        run_packet("after_abort", 1'b0, 1'b1, 1'b0, 20'h0, 20'h0, 7'h0, 3, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
